// File: rtl/match_stats_pkg.sv
// Shared types and constants for the match statistics block: FSM state,
// default counter width and the active-low 7-segment digit table.
package match_stats_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CNT_W_DEFAULT = 8;

    // Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
    localparam logic [6:0] SEG7_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_seg7.sv
// Combinational 4-bit hex digit to active-low 7-segment decoder.
module hex_seg7
    import match_stats_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG7_TABLE[digit];

endmodule

// File: rtl/match_stats.sv
// Statistics on a sequence-detector match output: run count, current and
// longest run length. Define MATCH_STATS_HEX_EN to add hex0/hex1 displays.
module match_stats
    import match_stats_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             z,
    input  logic             enable,
    input  logic             clear,
    output logic [CNT_W-1:0] run_count,
    output logic [CNT_W-1:0] cur_run,
    output logic [CNT_W-1:0] max_run,
    output logic             z_rise,
    output logic             overflow
`ifdef MATCH_STATS_HEX_EN
    ,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] run_next;

    // Saturated run length if the run continues this cycle; max_run compares
    // against this so it can never exceed CNT_MAX either.
    assign run_next = (cur_run == CNT_MAX) ? CNT_MAX : cur_run + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state     <= IDLE;
            run_count <= '0;
            cur_run   <= '0;
            max_run   <= '0;
            z_rise    <= 1'b0;
            overflow  <= 1'b0;
        end else if (enable) begin
            z_rise <= 1'b0;
            case (state)
                IDLE: begin
                    if (z) begin
                        state   <= RUN;
                        cur_run <= CNT_W'(1);
                        z_rise  <= 1'b1;
                        if (run_count == CNT_MAX)
                            overflow <= 1'b1;
                        else
                            run_count <= run_count + CNT_W'(1);
                        if (max_run == '0)
                            max_run <= CNT_W'(1);
                    end else begin
                        cur_run <= '0;
                    end
                end
                RUN: begin
                    if (z) begin
                        cur_run <= run_next;
                        if (run_next > max_run)
                            max_run <= run_next;
                    end else begin
                        state   <= IDLE;
                        cur_run <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            z_rise <= 1'b0;
        end
    end

`ifdef MATCH_STATS_HEX_EN
    logic [7:0] count_byte;
    logic [6:0] seg_lo;
    logic [6:0] seg_hi;

    // Narrow counters read as zero in the unused upper digit bits.
    generate
        if (CNT_W >= 8) begin : g_wide
            assign count_byte = run_count[7:0];
        end else begin : g_narrow
            assign count_byte = {{(8 - CNT_W){1'b0}}, run_count};
        end
    endgenerate

    hex_seg7 u_seg_lo (.digit(count_byte[3:0]), .seg(seg_lo));
    hex_seg7 u_seg_hi (.digit(count_byte[7:4]), .seg(seg_hi));

    always_ff @(posedge clock) begin
        if (reset) begin
            hex0 <= SEG7_TABLE[0];
            hex1 <= SEG7_TABLE[0];
        end else begin
            hex0 <= seg_lo;
            hex1 <= seg_hi;
        end
    end
`endif

endmodule
